// File: rtl/vx_random_placement_pkg.sv
// ----------------------------------------------------------------------------
// vx_random_placement_pkg
// Shared definitions for the randomized set placement and its inverse.
//   - Default widths for the 6-input Benes network and its 12-bit control.
//   - The control-bit-to-switch table: control bit k drives switch k, which
//     swaps index bits lo/hi when set. Switches within one column are
//     disjoint, so only the column order matters.
//   - benes6_perm: the forward placement permutation. It is used by the
//     inverse unit only when VX_UNPLACE_CHECK_EN is defined.
// ----------------------------------------------------------------------------
package vx_random_placement_pkg;

  localparam int INDEXBITS_DEF   = 6;
  localparam int CONTROLBITS_DEF = 12;
  localparam int BENES6_COLUMNS  = 5;
  localparam int BENES6_SWITCHES = CONTROLBITS_DEF;

  typedef logic [CONTROLBITS_DEF-1:0] ctrl_t;

  typedef struct packed {
    logic [2:0] col;  // column the switch sits in (0 = input side)
    logic [2:0] lo;   // first index bit routed through the switch
    logic [2:0] hi;   // second index bit routed through the switch
  } benes_switch_t;

  // Column widths are 3-2-2-2-3 switches, giving 12 switches in total.
  function automatic benes_switch_t benes6_switch(input int k);
    case (k)
      0:       return '{col: 3'd0, lo: 3'd0, hi: 3'd1};
      1:       return '{col: 3'd0, lo: 3'd2, hi: 3'd3};
      2:       return '{col: 3'd0, lo: 3'd4, hi: 3'd5};
      3:       return '{col: 3'd1, lo: 3'd1, hi: 3'd2};
      4:       return '{col: 3'd1, lo: 3'd3, hi: 3'd4};
      5:       return '{col: 3'd2, lo: 3'd0, hi: 3'd5};
      6:       return '{col: 3'd2, lo: 3'd2, hi: 3'd4};
      7:       return '{col: 3'd3, lo: 3'd0, hi: 3'd2};
      8:       return '{col: 3'd3, lo: 3'd3, hi: 3'd5};
      9:       return '{col: 3'd4, lo: 3'd0, hi: 3'd1};
      10:      return '{col: 3'd4, lo: 3'd2, hi: 3'd3};
      11:      return '{col: 3'd4, lo: 3'd4, hi: 3'd5};
      default: return '0;
    endcase
  endfunction

  // Forward placement: columns applied from input side (0) to output side.
  function automatic logic [INDEXBITS_DEF-1:0] benes6_perm(
    input logic [INDEXBITS_DEF-1:0] x,
    input ctrl_t                    c
  );
    logic [INDEXBITS_DEF-1:0] v;
    benes_switch_t            sw;
    logic                     tmp;
    v = x;
    for (int col = 0; col < BENES6_COLUMNS; col++) begin
      for (int k = 0; k < BENES6_SWITCHES; k++) begin
        sw = benes6_switch(k);
        if (int'(sw.col) == col && c[k]) begin
          tmp       = v[sw.lo];
          v[sw.lo]  = v[sw.hi];
          v[sw.hi]  = tmp;
        end
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/vx_benes_unpermute_6.sv
// ----------------------------------------------------------------------------
// vx_benes_unpermute_6
// Combinational inverse of the 6-input placement Benes network. Every switch
// is a conditional swap and therefore its own inverse, so walking the same
// switch columns from the output side back to the input side, with the same
// control bit per switch, undoes the forward permutation.
// Ports:
//   in      [5:0]   physical (permuted) set index
//   control [11:0]  Benes control word, one bit per switch
//   out     [5:0]   logical (unpermuted) set index
// ----------------------------------------------------------------------------
module vx_benes_unpermute_6
  import vx_random_placement_pkg::*;
(
  input  logic [5:0] in,
  input  ctrl_t      control,
  output logic [5:0] out
);

  logic [5:0]    v;
  logic          tmp;
  benes_switch_t sw;

  // NOTE: every variable written here gets a value before any conditional
  // path, so no latch is inferred; blocking '=' is right in combinational code.
  always_comb begin
    v   = in;
    tmp = 1'b0;
    sw  = '0;
    for (int col = BENES6_COLUMNS - 1; col >= 0; col--) begin
      for (int k = 0; k < BENES6_SWITCHES; k++) begin
        sw = benes6_switch(k);
        if (int'(sw.col) == col && control[k]) begin
          tmp      = v[sw.lo];
          v[sw.lo] = v[sw.hi];
          v[sw.hi] = tmp;
        end
      end
    end
    out = v;
  end

endmodule

// File: rtl/vx_random_unplacement.sv
// ----------------------------------------------------------------------------
// vx_random_unplacement
// Reconstructs a line address from its physical set index and stored tag by
// inverting the cache's randomized set placement. The seed mirror tracks the
// current placement seed plus one previous-epoch seed.
// Two-stage valid/ready pipeline:
//   stage 1 captures tag, index and the control word,
//   stage 2 holds {tag, unperm(index, ctrl)} and drives the response.
// Optional build macro: VX_UNPLACE_CHECK_EN adds a forward re-permutation of
// the stage-2 result, a sticky check_error flag and a simulation assertion.
// Without it check_error is tied low and no forward network exists.
// Ports:
//   clk, reset (async, active-high)
//   reseed, seed_in           placement reseed pulse and new seed
//   req_valid/req_ready       request handshake
//   req_index, req_tag        physical set index and stored tag
//   req_epoch                 0 = current seed, 1 = previous seed
//   rsp_valid/rsp_ready       response handshake
//   rsp_address               reconstructed line address
//   busy                      any request in flight
//   check_error               sticky round-trip mismatch flag
// ----------------------------------------------------------------------------
module vx_random_unplacement
  import vx_random_placement_pkg::*;
#(
  parameter int INDEXBITS   = INDEXBITS_DEF,
  parameter int ADDRESSBITS = 24,
  parameter int CONTROLBITS = CONTROLBITS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reseed,
  input  logic [CONTROLBITS-1:0]           seed_in,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [INDEXBITS-1:0]             req_index,
  input  logic [ADDRESSBITS-INDEXBITS-1:0] req_tag,
  input  logic                             req_epoch,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ADDRESSBITS-1:0]           rsp_address,
  output logic                             busy,
  output logic                             check_error
);

  localparam int TAGBITS = ADDRESSBITS - INDEXBITS;

  // Seed mirror
  logic [CONTROLBITS-1:0] cur_seed_q, cur_seed_d;
  logic [CONTROLBITS-1:0] prev_seed_q, prev_seed_d;

  // Stage 1
  logic                   s1_valid_q, s1_valid_d;
  logic [TAGBITS-1:0]     s1_tag_q, s1_tag_d;
  logic [INDEXBITS-1:0]   s1_index_q, s1_index_d;
  logic [CONTROLBITS-1:0] s1_ctrl_q, s1_ctrl_d;

  // Stage 2
  logic                   s2_valid_q, s2_valid_d;
  logic [ADDRESSBITS-1:0] s2_addr_q, s2_addr_d;

  logic                   s2_ready;
  logic                   req_fire;
  logic                   s2_load;
  logic [CONTROLBITS-1:0] req_ctrl;
  logic [INDEXBITS-1:0]   unperm_index;

  // A stage may take new data when the stage below it is empty or draining.
  assign s2_ready  = ~s2_valid_q | rsp_ready;
  assign req_ready = ~s1_valid_q | s2_ready;
  assign req_fire  = req_valid & req_ready;
  assign s2_load   = s1_valid_q & s2_ready;

  // Uses the seed registers as they stand before this edge, so a request
  // accepted together with a reseed decodes with the pre-reseed seeds.
  assign req_ctrl = req_tag[CONTROLBITS-1:0] ^ (req_epoch ? prev_seed_q : cur_seed_q);

  vx_benes_unpermute_6 u_unperm (
    .in      (s1_index_q),
    .control (s1_ctrl_q),
    .out     (unperm_index)
  );

  always_comb begin
    cur_seed_d  = cur_seed_q;
    prev_seed_d = prev_seed_q;
    if (reseed) begin
      prev_seed_d = cur_seed_q;
      cur_seed_d  = seed_in;
    end

    s1_valid_d = req_fire | (s1_valid_q & ~s2_load);
    s1_tag_d   = req_fire ? req_tag   : s1_tag_q;
    s1_index_d = req_fire ? req_index : s1_index_q;
    s1_ctrl_d  = req_fire ? req_ctrl  : s1_ctrl_q;

    // A stalled response keeps both valid and data untouched.
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    s2_addr_d  = s2_load ? {s1_tag_q, unperm_index} : s2_addr_q;
  end

  // NOTE: the datapath registers are few and narrow, so they are reset too;
  // this makes rsp_address read 0 after reset instead of stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_seed_q  <= '0;
      prev_seed_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_index_q  <= '0;
      s1_ctrl_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, e.g. prev_seed takes the old cur_seed.
      cur_seed_q  <= cur_seed_d;
      prev_seed_q <= prev_seed_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_index_q  <= s1_index_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
    end
  end

  assign rsp_valid   = s2_valid_q;
  assign rsp_address = s2_addr_q;
  assign busy        = s1_valid_q | s2_valid_q;

`ifdef VX_UNPLACE_CHECK_EN
  // Stage 2 keeps the original index and the control word, so the result
  // it holds can be pushed back through the forward network and compared.
  logic [INDEXBITS-1:0]   s2_src_index_q, s2_src_index_d;
  logic [CONTROLBITS-1:0] s2_ctrl_q, s2_ctrl_d;
  logic                   check_error_q, check_error_d;
  logic                   roundtrip_bad;

  assign roundtrip_bad =
    s2_valid_q & (benes6_perm(s2_addr_q[INDEXBITS-1:0], s2_ctrl_q) != s2_src_index_q);

  always_comb begin
    s2_src_index_d = s2_load ? s1_index_q : s2_src_index_q;
    s2_ctrl_d      = s2_load ? s1_ctrl_q  : s2_ctrl_q;
    check_error_d  = check_error_q | roundtrip_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_src_index_q <= '0;
      s2_ctrl_q      <= '0;
      check_error_q  <= 1'b0;
    end else begin
      s2_src_index_q <= s2_src_index_d;
      s2_ctrl_q      <= s2_ctrl_d;
      check_error_q  <= check_error_d;
    end
  end

  assign check_error = check_error_q;

  a_roundtrip : assert property (@(posedge clk) disable iff (reset) !roundtrip_bad);
`else
  assign check_error = 1'b0;
`endif

endmodule

// File: tb/tb_vx_random_unplacement.sv
// ----------------------------------------------------------------------------
// tb_vx_random_unplacement
// Self-checking bench for vx_random_unplacement. The reference keeps its own
// copy of the placement switch list, computes the forward placement, and
// finds the expected logical index by searching all 64 candidates for the
// one that places onto the requested physical index.
// ----------------------------------------------------------------------------
module tb_vx_random_unplacement;

  logic        clk = 1'b0;
  logic        reset;
  logic        reseed;
  logic [11:0] seed_in;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic [17:0] req_tag;
  logic        req_epoch;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_address;
  logic        busy;
  logic        check_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vx_random_unplacement dut (
    .clk         (clk),
    .reset       (reset),
    .reseed      (reseed),
    .seed_in     (seed_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_tag     (req_tag),
    .req_epoch   (req_epoch),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_address (rsp_address),
    .busy        (busy),
    .check_error (check_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference placement: switch k swaps index bits SW_LO[k]/SW_HI[k]
  // when control bit k is set, applied in ascending k (column) order.
  localparam int SW_LO [12] = '{0, 2, 4, 1, 3, 0, 2, 0, 3, 0, 2, 4};
  localparam int SW_HI [12] = '{1, 3, 5, 2, 4, 5, 4, 2, 5, 1, 3, 5};

  function automatic logic [5:0] ref_perm(input logic [5:0] x, input logic [11:0] c);
    logic [5:0] v;
    logic       t;
    v = x;
    for (int k = 0; k < 12; k++) begin
      if (c[k]) begin
        t            = v[SW_LO[k]];
        v[SW_LO[k]]  = v[SW_HI[k]];
        v[SW_HI[k]]  = t;
      end
    end
    return v;
  endfunction

  function automatic logic [5:0] ref_unperm(input logic [5:0] y, input logic [11:0] c);
    for (int v = 0; v < 64; v++) begin
      if (ref_perm(6'(v), c) == y) return 6'(v);
    end
    return 6'h00;
  endfunction

  // ---- scoreboard
  typedef struct {
    logic [23:0] addr;
    logic [5:0]  idx;
    logic [11:0] ctrl;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] m_cur  = '0;
  logic [11:0] m_prev = '0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_addr  = '0;
  int          ready_low_cycles = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      m_cur      = '0;
      m_prev     = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_addr", 32'(rsp_address), 32'(prev_addr));
      end
      if (rsp_valid && exp_q.size() == 0) begin
        check("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else if (rsp_valid && rsp_ready) begin
        e = exp_q.pop_front();
        check("rsp_addr", 32'(rsp_address), 32'(e.addr));
        check("roundtrip", 32'(ref_perm(rsp_address[5:0], e.ctrl)), 32'(e.idx));
      end
      if (req_valid && req_ready) begin
        e.ctrl = req_tag[11:0] ^ (req_epoch ? m_prev : m_cur);
        e.idx  = req_index;
        e.addr = {req_tag, ref_unperm(req_index, e.ctrl)};
        exp_q.push_back(e);
      end
      if (req_valid && !req_ready) ready_low_cycles++;
      if (reseed) begin
        m_prev = m_cur;
        m_cur  = seed_in;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_addr  = rsp_address;
    end
  end

  // ---- stimulus helpers (inputs change 1 time unit after the rising edge)
  task automatic send(input logic [5:0] idx, input logic [17:0] tag, input logic ep);
    bit done = 0;
    req_valid = 1'b1;
    req_index = idx;
    req_tag   = tag;
    req_epoch = ep;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reseed(input logic [11:0] s);
    reseed  = 1'b1;
    seed_in = s;
    @(posedge clk);
    #1;
    reseed = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || busy) && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  bit rand_done;

  initial begin
    int busy_cnt;
    int first_rsp;
    reset     = 1'b1;
    reseed    = 1'b0;
    seed_in   = '0;
    req_valid = 1'b0;
    req_index = '0;
    req_tag   = '0;
    req_epoch = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Reset state
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_addr", 32'(rsp_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_check_error", 32'(check_error), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency and busy window with identity control
    send(6'h2A, 18'h00000, 1'b0);
    busy_cnt  = 0;
    first_rsp = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (rsp_valid && first_rsp < 0) begin
        first_rsp = i;
        check("lat_addr", 32'(rsp_address), 32'h00002A);
      end
    end
    check("lat_busy_cycles", 32'(busy_cnt), 32'd2);
    check("lat_first_rsp", 32'(first_rsp), 32'd1);
    @(posedge clk);
    #1;

    // Exhaustive indices under seed A5C
    do_reseed(12'hA5C);
    for (int i = 0; i < 64; i++) send(6'(i), 18'h3F123, 1'b0);
    drain();

    // Two reseeds: epoch 1 uses 111, epoch 0 uses 222
    do_reseed(12'h111);
    do_reseed(12'h222);
    send(6'h15, 18'h2BEEF, 1'b1);
    send(6'h15, 18'h2BEEF, 1'b0);
    send(6'h3C, 18'h0C0DE, 1'b1);
    drain();

    // Request accepted in the same cycle as a reseed
    do_reseed(12'h111);
    drain();
    reseed    = 1'b1;
    seed_in   = 12'h333;
    req_valid = 1'b1;
    req_index = 6'h27;
    req_tag   = 18'h1A5A5;
    req_epoch = 1'b0;
    @(negedge clk);
    check("same_cycle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    reseed    = 1'b0;
    req_valid = 1'b0;
    drain();

    // Back-to-back burst with the response side stalled for four cycles
    ready_low_cycles = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(6'($urandom_range(0, 63)), 18'($urandom), 1'(i % 2));
      end
      begin
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();
    check("burst_ready_dropped", 32'(ready_low_cycles > 0), 32'd1);

    // Randomized traffic, back-pressure and reseeds
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(6'($urandom_range(0, 63)), 18'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          seed_in = 12'($urandom);
          reseed  = ($urandom_range(0, 15) == 0);
        end
      end
    join
    reseed    = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset with two requests in flight
    send(6'h01, 18'h00ABC, 1'b0);
    send(6'h02, 18'h00DEF, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    check("postrst_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
